pid_sched: RTL

Time-multiplexed PID scheduler for the quad-rotor drive path. One compensator datapath is shared across `NUM_CH` motor channels. The block holds per-channel error and motor-set history, and walks the channels round-robin, one per cycle, on each sample tick. It sits between the directional controller (`rpm_set`) and the motor drivers (`mot_set`).

---
 rtl/pid_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pid_sched.sv
// Time-multiplexed PID scheduler: one shared compensator walks NUM_CH channels per sample tick.
// Optional PID_SCHED_SAT_EN: saturate 17-bit intermediate results instead of wrapping them.
module pid_sched #(
  parameter int NUM_CH = 4,
  parameter int SHIFT  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [16*NUM_CH-1:0]   rpm_set,
  input  logic [16*NUM_CH-1:0]   rpm_sense,
  input  logic [NUM_CH-1:0]      enable_mask,
  input  logic                   clear_overrun,
  output logic [16*NUM_CH-1:0]   mot_set,
  output logic                   mot_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] CALC    = 2'd2;
  localparam logic [1:0] PUBLISH = 2'd3;
  localparam int         IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  logic [1:0]              state_r;
  logic [1:0]              state_next_s;
  logic [IW-1:0]           idx_r;
  logic signed [15:0]      set_snap_r   [NUM_CH];
  logic signed [15:0]      sense_snap_r [NUM_CH];
  logic [NUM_CH-1:0]       mask_snap_r;
  logic signed [15:0]      e_prev_r     [NUM_CH];
  logic signed [15:0]      x_prev_r     [NUM_CH];
  logic [16*NUM_CH-1:0]    mot_set_r;
  logic                    mot_valid_r;
  logic                    overrun_r;
  logic signed [15:0]      x_shift_s;
  logic signed [16:0]      e_wide_s;
  logic signed [16:0]      x_wide_s;
  logic signed [15:0]      e_new_s;
  logic signed [15:0]      x_new_s;
  logic                    drop_tick_s;

  // Narrow a 17-bit result to 16 bits: clamp when saturation is built in, otherwise wrap.
  function automatic logic signed [15:0] narrow17(input logic signed [16:0] v);
`ifdef PID_SCHED_SAT_EN
    if (v[16] != v[15]) begin
      narrow17 = v[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      narrow17 = $signed(v[15:0]);
    end
`else
    narrow17 = $signed(v[15:0]);
`endif
  endfunction

  assign mot_set   = mot_set_r;
  assign mot_valid = mot_valid_r;
  assign busy      = (state_r != IDLE);
  assign overrun   = overrun_r;

  // Shared compensator datapath for the channel selected by idx_r.
  always_comb begin
    x_shift_s = x_prev_r[idx_r] >>> SHIFT;
    e_wide_s  = {set_snap_r[idx_r][15], set_snap_r[idx_r]}
              - {sense_snap_r[idx_r][15], sense_snap_r[idx_r]};
    x_wide_s  = {e_prev_r[idx_r][15], e_prev_r[idx_r]} + {x_shift_s[15], x_shift_s};
    e_new_s   = narrow17(e_wide_s);
    x_new_s   = narrow17(x_wide_s);
    drop_tick_s = sample_tick && (state_r != IDLE);
  end

  // Next-state logic for the sample sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: state_next_s = CALC;
      CALC: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = PUBLISH;
        end else begin
          state_next_s = CALC;
        end
      end
      PUBLISH: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Sequencer state, channel index, input snapshot, publish and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      mask_snap_r <= '0;
      mot_set_r   <= '0;
      mot_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        set_snap_r[i]   <= 16'sd0;
        sense_snap_r[i] <= 16'sd0;
      end
    end else begin
      state_r     <= state_next_s;
      mot_valid_r <= (state_r == PUBLISH);
      if (drop_tick_s) begin
        overrun_r <= 1'b1;
      end else if (clear_overrun) begin
        overrun_r <= 1'b0;
      end
      if (state_r == LOAD) begin
        idx_r       <= '0;
        mask_snap_r <= enable_mask;
        for (int i = 0; i < NUM_CH; i++) begin
          set_snap_r[i]   <= $signed(rpm_set[16*i +: 16]);
          sense_snap_r[i] <= $signed(rpm_sense[16*i +: 16]);
        end
      end else if (state_r == CALC && idx_r != LAST_IDX) begin
        idx_r <= idx_r + 1'b1;
      end
      if (state_r == PUBLISH) begin
        for (int i = 0; i < NUM_CH; i++) begin
          mot_set_r[16*i +: 16] <= x_prev_r[i];
        end
      end
    end
  end

  // Per-channel history write-back; disabled channels are flushed to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e_prev_r[i] <= 16'sd0;
        x_prev_r[i] <= 16'sd0;
      end
    end else if (state_r == CALC) begin
      if (mask_snap_r[idx_r]) begin
        e_prev_r[idx_r] <= e_new_s;
        x_prev_r[idx_r] <= x_new_s;
      end else begin
        e_prev_r[idx_r] <= 16'sd0;
        x_prev_r[idx_r] <= 16'sd0;
      end
    end
  end

endmodule
